// File: rtl/dmem_pkg.sv
// Shared constants and types for the processor data memory.
// Build option: DMEM_ADDR_CHECK_EN enables out-of-range address detection
// in dmem_addr_decode; without it, upper address bits alias modulo depth.
package dmem_pkg;

  localparam int DMEM_WIDTH = 32;
  localparam int DMEM_DEPTH = 1024;
  localparam int DMEM_IDX_W = 10;

  typedef logic [DMEM_WIDTH-1:0] dmem_word_t;
  typedef logic [DMEM_IDX_W-1:0] dmem_idx_t;

endpackage : dmem_pkg

// File: rtl/dmem_addr_decode.sv
// Word-address to array-index conversion for the data memory.
// Build option: DMEM_ADDR_CHECK_EN -- when defined, in_range is low for any
// address with bits set above the index field; otherwise in_range is tied
// high and the upper bits are ignored (addresses wrap modulo depth).
module dmem_addr_decode
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = DMEM_IDX_W
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              in_range
);

  // Low address bits select the word directly; addresses are word addresses.
  assign idx = addr[IDX_W-1:0];

`ifdef DMEM_ADDR_CHECK_EN
  // Any nonzero bit above the index field marks the address out of range.
  assign in_range = (addr[ADDR_W-1:IDX_W] == {(ADDR_W-IDX_W){1'b0}});
`else
  logic unused_upper_s;

  // Upper bits deliberately ignored so addresses alias modulo depth.
  assign unused_upper_s = ^addr[ADDR_W-1:IDX_W];
  assign in_range       = 1'b1;
`endif

endmodule : dmem_addr_decode

// File: rtl/data_memory.sv
// Word-addressed data memory: one combinational read port, one synchronous
// write port, asynchronous active-high reset that clears every word.
// Build option: DMEM_ADDR_CHECK_EN -- out-of-range reads return 0 and
// out-of-range writes are dropped (handled via dmem_addr_decode).
module data_memory
  import dmem_pkg::*;
#(
  parameter int WIDTH  = DMEM_WIDTH,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic              write_en,
  input  logic [WIDTH-1:0]  write_data,
  output logic [WIDTH-1:0]  read_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [IDX_W-1:0] rd_idx_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic             rd_in_range_s;
  logic             wr_in_range_s;

  dmem_addr_decode #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_rd_decode (
    .addr     (read_addr),
    .idx      (rd_idx_s),
    .in_range (rd_in_range_s)
  );

  dmem_addr_decode #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_wr_decode (
    .addr     (write_addr),
    .idx      (wr_idx_s),
    .in_range (wr_in_range_s)
  );

  // Array storage: reset clears all words and overrides any coincident write.
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (write_en && wr_in_range_s) begin
      mem_r[wr_idx_s] <= write_data;
    end
  end

  // Combinational read mux; zero during reset or for a rejected address.
  always_comb begin
    read_data = {WIDTH{1'b0}};
    if (reset_b) begin
      read_data = {WIDTH{1'b0}};
    end else if (rd_in_range_s) begin
      read_data = mem_r[rd_idx_s];
    end else begin
      read_data = {WIDTH{1'b0}};
    end
  end

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory with a queue scoreboard.
module tb_data_memory;

  logic        clk;
  logic        reset_b;
  logic [31:0] read_addr;
  logic [31:0] write_addr;
  logic        write_en;
  logic [31:0] write_data;
  logic [31:0] read_data;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  data_memory dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .read_addr  (read_addr),
    .write_addr (write_addr),
    .write_en   (write_en),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // Record the value read_data should show at the next sample point.
  task automatic push_exp(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    exp_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare with the DUT output.
  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard: observed empty queue required an entry");
    end else begin
      e = exp_q.pop_front();
      vectors++;
      assert (read_data === e.value)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h required %h", e.tag, read_data, e.value);
      end
    end
  endtask

  // Set read address, let the combinational path settle, then compare.
  task automatic read_check(input logic [31:0] addr, input logic [31:0] value, input string tag);
    read_addr = addr;
    push_exp(tag, value);
    #1;
    check_out();
  endtask

  // One full write cycle, driven on the falling edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    write_addr = addr;
    write_data = data;
    write_en   = 1'b1;
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_b     = 1'b1;
    read_addr   = 32'd0;
    write_addr  = 32'd0;
    write_en    = 1'b0;
    write_data  = 32'd0;

    // Reset state
    @(posedge clk);
    #1;
    read_check(32'd0, 32'h0000_0000, "reset_addr0");
    read_check(32'd1023, 32'h0000_0000, "reset_addr1023");
    @(negedge clk);
    reset_b = 1'b0;
    read_check(32'd1, 32'h0000_0000, "post_reset_addr1");

    // Reset clear without a clock edge
    do_write(32'd1, 32'hFFFF_FFFE);
    do_write(32'd1023, 32'h1234_5678);
    read_check(32'd1, 32'hFFFF_FFFE, "pre_clear_addr1");
    read_check(32'd1023, 32'h1234_5678, "pre_clear_addr1023");
    @(negedge clk);
    #1;
    reset_b = 1'b1;
    read_check(32'd1, 32'h0000_0000, "during_clear_addr1");
    read_check(32'd1023, 32'h0000_0000, "during_clear_addr1023");
    reset_b = 1'b0;
    read_check(32'd1, 32'h0000_0000, "after_clear_addr1");
    read_check(32'd1023, 32'h0000_0000, "after_clear_addr1023");

    // Write then read, with no bypass before the edge
    @(negedge clk);
    write_addr = 32'd1;
    write_data = 32'hFFFF_FFFD;
    write_en   = 1'b1;
    read_check(32'd1, 32'h0000_0000, "wr_before_edge");
    @(posedge clk);
    #1;
    write_en = 1'b0;
    push_exp("wr_after_edge", 32'hFFFF_FFFD);
    check_out();
    read_check(32'd5, 32'h0000_0000, "wr_other_addr5");

    // write_en low for three edges
    @(negedge clk);
    write_addr = 32'd2;
    write_data = 32'hFFFF_FFFB;
    write_en   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    read_check(32'd2, 32'h0000_0000, "wen_low_addr2");

    // Same-cycle read and write to one index
    @(negedge clk);
    write_addr = 32'd2;
    write_data = 32'hFFFF_FFFD;
    write_en   = 1'b1;
    read_check(32'd2, 32'h0000_0000, "same_before_edge");
    @(posedge clk);
    #1;
    write_en = 1'b0;
    push_exp("same_after_edge", 32'hFFFF_FFFD);
    check_out();
    read_check(32'd1, 32'hFFFF_FFFD, "same_addr1_intact");

    // Distinct data patterns over a block of addresses, including the top word
    for (int i = 0; i < 6; i++) begin
      do_write(32'd16 + 32'(i), 32'h0F0F_0000 ^ (32'(i) * 32'h1111_1111));
    end
    do_write(32'd1023, 32'h8000_0001);
    for (int i = 0; i < 6; i++) begin
      read_check(32'd16 + 32'(i), 32'h0F0F_0000 ^ (32'(i) * 32'h1111_1111), "pattern");
    end
    read_check(32'd1023, 32'h8000_0001, "top_word");
    read_check(32'd0, 32'h0000_0000, "bottom_word");

    // Address wrap / out-of-range handling
    do_write(32'd1025, 32'hA5A5_A5A5);
`ifdef DMEM_ADDR_CHECK_EN
    read_check(32'd1, 32'hFFFF_FFFD, "oor_addr1_unchanged");
    read_check(32'd1025, 32'h0000_0000, "oor_read_zero");
`else
    read_check(32'd1, 32'hA5A5_A5A5, "wrap_addr1");
    read_check(32'd1025, 32'hA5A5_A5A5, "wrap_addr1025");
`endif

    // Reset coincident with a write edge: the write is lost
    @(negedge clk);
    write_addr = 32'd3;
    write_data = 32'h0000_0001;
    write_en   = 1'b1;
    @(posedge clk);
    reset_b = 1'b1;
    #1;
    read_check(32'd3, 32'h0000_0000, "rst_vs_wr_during");
    @(negedge clk);
    write_en = 1'b0;
    reset_b  = 1'b0;
    read_check(32'd3, 32'h0000_0000, "rst_vs_wr_after");
    read_check(32'd16, 32'h0000_0000, "rst_vs_wr_other");

    // Memory works again after reset
    do_write(32'd3, 32'h0BAD_F00D);
    read_check(32'd3, 32'h0BAD_F00D, "post_reset_write");

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: observed %0d leftover required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_data_memory
